// File: rtl/dtc_stub_pkg.sv
// Shared constants, frame field layout and FSM encoding for the stub dispatch controller.
// Frame layout: [255:244] reserved, [243:240] stub count, stub k at [239-24k -: 24].
package dtc_stub_pkg;

   localparam int unsigned FRAME_W  = 256;
   localparam int unsigned STUB_W   = 24;
   localparam int unsigned STUB_TOP = 239;
   localparam int unsigned CHIP_LSB = 21;
   localparam int unsigned CHIP_W   = 3;
   localparam int unsigned PAY_W    = 21;
   localparam int unsigned CNT_LSB  = 240;
   localparam int unsigned CNT_W    = 4;

   localparam int unsigned N_STUB_DFLT = 10;
   localparam int unsigned N_CHIP_DFLT = 8;
   localparam int unsigned ADDR_W_DFLT = 7;
   localparam int unsigned DATA_W_DFLT = 21;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StDispatch = 2'd1,
      StDone     = 2'd2
   } dtc_state_e;

   // Shift stub k up to the top stub slot so the select stays in range for any k.
   function automatic logic [STUB_W-1:0] get_stub(input logic [FRAME_W-1:0] frame,
                                                  input logic [CNT_W-1:0]   k);
      logic [FRAME_W-1:0] sh;
      sh = frame << (k * STUB_W);
      return sh[STUB_TOP -: STUB_W];
   endfunction

   function automatic logic [CNT_W-1:0] clip_count(input logic [CNT_W-1:0] cnt,
                                                   input int unsigned      lim);
      return (cnt > lim) ? CNT_W'(lim) : cnt;
   endfunction

endpackage

// File: rtl/stub_dispatch_ctrl_if.sv
// Frame input and per-chip BRAM write bus of the stub dispatch controller.
interface stub_dispatch_ctrl_if
   import dtc_stub_pkg::*;
#(
   parameter int unsigned N_CHIP = N_CHIP_DFLT,
   parameter int unsigned ADDR_W = ADDR_W_DFLT,
   parameter int unsigned DATA_W = DATA_W_DFLT
) ();

   logic                     frame_valid;
   logic [FRAME_W-1:0]       frame_data;
   logic                     frame_ready;
   logic                     clear_ptr;
   logic [N_CHIP-1:0]        wr_en;
   logic [N_CHIP*ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     busy;
   logic                     frame_done;
   logic [N_CHIP-1:0]        wrap_flag;
   logic [7:0]               drop_cnt;

   modport master (
      output frame_valid, frame_data, clear_ptr,
      input  frame_ready, wr_en, wr_addr, wr_data, busy, frame_done, wrap_flag, drop_cnt
   );

   modport slave (
      input  frame_valid, frame_data, clear_ptr,
      output frame_ready, wr_en, wr_addr, wr_data, busy, frame_done, wrap_flag, drop_cnt
   );

endinterface

// File: rtl/stub_wr_ptr.sv
// Per-chip BRAM write pointer with a sticky wrap flag; clear overrides a coincident increment.
module stub_wr_ptr #(
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clr,
   output logic [ADDR_W-1:0] ptr,
   output logic              wrap
);

   logic [ADDR_W-1:0] ptr_q;
   logic              wrap_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q  <= '0;
         wrap_q <= 1'b0;
      end else if (clr) begin
         ptr_q  <= '0;
         wrap_q <= 1'b0;
      end else if (inc) begin
         ptr_q <= ptr_q + 1'b1;
         if (&ptr_q) wrap_q <= 1'b1;
      end
   end

   assign ptr  = ptr_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/stub_dispatch_ctrl.sv
// Frame-to-BRAM stub dispatcher: unpacks up to N_STUB stubs per frame and issues one per
// cycle to the owning chip's BRAM at that chip's running write pointer.
module stub_dispatch_ctrl
   import dtc_stub_pkg::*;
#(
   parameter int unsigned N_CHIP = N_CHIP_DFLT,
   parameter int unsigned N_STUB = N_STUB_DFLT,
   parameter int unsigned ADDR_W = ADDR_W_DFLT,
   parameter int unsigned DATA_W = DATA_W_DFLT
) (
   input logic                 clk,
   input logic                 rst,
   stub_dispatch_ctrl_if.slave bus
);

   dtc_state_e               state_q;
   logic                     ready_q;
   logic                     busy_q;
   logic                     done_q;
   logic [FRAME_W-1:0]       frame_q;
   logic [CNT_W-1:0]         n_q;
   logic [CNT_W-1:0]         idx_q;
   logic [CNT_W-1:0]         n_acc;
   logic [N_CHIP-1:0]        wr_en_q;
   logic [N_CHIP*ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0]        wr_data_q;
   logic [7:0]               drop_q;
   logic [N_CHIP-1:0]        inc;
   logic [N_CHIP-1:0]        wrap;
   logic [ADDR_W-1:0]        ptr [N_CHIP];
   logic [N_CHIP*ADDR_W-1:0] ptr_packed;
   logic                     accept;
   logic                     issue;
   logic [STUB_W-1:0]        stub;

   assign accept = bus.frame_valid & ready_q;
   assign n_acc  = clip_count(bus.frame_data[CNT_LSB +: CNT_W], N_STUB);

   // Stub 0 is taken straight from the input frame so it appears in the cycle after accept.
   always_comb begin
      issue = 1'b0;
      stub  = '0;
      if (accept && (n_acc != '0)) begin
         issue = 1'b1;
         stub  = get_stub(bus.frame_data, '0);
      end else if ((state_q == StDispatch) && (idx_q < n_q)) begin
         issue = 1'b1;
         stub  = get_stub(frame_q, idx_q);
      end
   end

   // Chip IDs beyond N_CHIP match no strobe but still use up their issue slot.
   always_comb begin
      inc = '0;
      for (int i = 0; i < int'(N_CHIP); i++) begin
         if (issue && (int'(stub[CHIP_LSB +: CHIP_W]) == i)) inc[i] = 1'b1;
      end
   end

   for (genvar c = 0; c < N_CHIP; c++) begin : g_ptr
      stub_wr_ptr #(
         .ADDR_W(ADDR_W)
      ) u_ptr (
         .clk (clk),
         .rst (rst),
         .inc (inc[c]),
         .clr (bus.clear_ptr),
         .ptr (ptr[c]),
         .wrap(wrap[c])
      );
      assign ptr_packed[c*ADDR_W +: ADDR_W] = ptr[c];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         frame_q   <= '0;
         n_q       <= '0;
         idx_q     <= '0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         drop_q    <= '0;
      end else begin
         // Pre-increment pointers: the strobed chip's slot holds the address being written.
         wr_en_q   <= inc;
         wr_addr_q <= ptr_packed;
         done_q    <= 1'b0;
         if (issue) wr_data_q <= stub[DATA_W-1:0];
         if (bus.frame_valid && !ready_q && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               if (accept) begin
                  frame_q <= bus.frame_data;
                  n_q     <= n_acc;
                  idx_q   <= CNT_W'(1);
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (n_acc == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StDispatch;
                  end
               end
            end
            StDispatch: begin
               if (idx_q < n_q) begin
                  idx_q <= idx_q + 1'b1;
               end else begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.frame_ready = ready_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = done_q;
   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.wrap_flag   = wrap;
   assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_stub_dispatch_ctrl.sv
// Self-checking bench for stub_dispatch_ctrl: directed scenarios plus random frames checked
// against a per-chip pointer/wrap/drop model derived from the frame format.
module tb_stub_dispatch_ctrl;

   localparam int unsigned NC = 8;
   localparam int unsigned AW = 7;
   localparam int unsigned DW = 21;
   localparam int unsigned NS = 10;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   stub_dispatch_ctrl_if #(.N_CHIP(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

   stub_dispatch_ctrl #(
      .N_CHIP(NC),
      .N_STUB(NS),
      .ADDR_W(AW),
      .DATA_W(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   int          mptr [NC];
   logic [NC-1:0] mwrap;
   int          mdrop;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] put_stub(input logic [255:0] f, input int k, input int chip,
                                             input int pay);
      logic [255:0] r;
      r = f;
      r[239-24*k -: 24] = {chip[2:0], pay[20:0]};
      return r;
   endfunction

   function automatic logic [255:0] rand_frame(input int cnt);
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
      r[243:240] = cnt[3:0];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(NC); i++) mptr[i] = 0;
      mwrap = '0;
   endtask

   task automatic pulse_clear();
      bus.clear_ptr = 1'b1;
      @(negedge clk);
      bus.clear_ptr = 1'b0;
      model_reset();
   endtask

   // Offer one frame from a negedge in IDLE; optionally keep frame_valid high for
   // extra cycles with garbage data, which must be dropped and counted.
   task automatic run_frame(input logic [255:0] f, input int extra_valid);
      int n;
      int c;
      logic [23:0] s;
      logic [NC-1:0] een;
      n = int'(f[243:240]);
      if (n > int'(NS)) n = NS;
      check("ready_before", bus.frame_ready, 1);
      check("wrap_before", bus.wrap_flag, mwrap);
      bus.frame_valid = 1'b1;
      bus.frame_data  = f;
      for (int k = 0; k <= n; k++) begin
         @(negedge clk);
         check("busy", bus.busy, 1);
         check("ready_busy", bus.frame_ready, 0);
         if (k < n) begin
            s   = f[239-24*k -: 24];
            c   = int'(s[23:21]);
            een = '0;
            if (c < int'(NC)) een[c] = 1'b1;
            check("wr_en", bus.wr_en, een);
            check("done_early", bus.frame_done, 0);
            if (c < int'(NC)) begin
               check("wr_addr", bus.wr_addr[c*AW +: AW], mptr[c]);
               check("wr_data", bus.wr_data, s[20:0]);
               if (mptr[c] == (1 << AW) - 1) begin
                  mptr[c]  = 0;
                  mwrap[c] = 1'b1;
               end else begin
                  mptr[c]++;
               end
            end
         end else begin
            check("wr_en_done", bus.wr_en, 0);
            check("frame_done", bus.frame_done, 1);
         end
         if (k < extra_valid) begin
            bus.frame_valid = 1'b1;
            bus.frame_data  = rand_frame($urandom_range(0, 15));
            if (mdrop < 255) mdrop++;
         end else begin
            bus.frame_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("ready_after", bus.frame_ready, 1);
      check("busy_after", bus.busy, 0);
      check("done_after", bus.frame_done, 0);
      check("wr_en_after", bus.wr_en, 0);
      check("drop_cnt", bus.drop_cnt, mdrop);
      check("wrap_flag", bus.wrap_flag, mwrap);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] f;
      rst             = 1'b1;
      bus.frame_valid = 1'b0;
      bus.frame_data  = '0;
      bus.clear_ptr   = 1'b0;
      model_reset();
      mdrop = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", bus.frame_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_wrap", bus.wrap_flag, 0);
      check("rst_drop", bus.drop_cnt, 0);
      check("rst_done", bus.frame_done, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_post_rst", bus.frame_ready, 1);

      // Ten stubs over chips 0..7,0,1 with payloads 1..10
      f = '0;
      f[243:240] = 4'd10;
      for (int k = 0; k < 10; k++) f = put_stub(f, k, k % 8, k + 1);
      run_frame(f, 0);
      check("chip0_next", mptr[0] == 2 && mptr[1] == 2, 1);

      // Empty frame, then over-range count clipped to N_STUB
      run_frame(rand_frame(0), 0);
      run_frame(rand_frame(15), 0);

      // Valid held three cycles while busy
      run_frame(rand_frame(10), 3);
      check("drop_cnt_3", bus.drop_cnt, 3);

      // 130 stubs to chip 3 across 13 frames
      pulse_clear();
      for (int fr = 0; fr < 13; fr++) begin
         f = rand_frame(10);
         for (int k = 0; k < 10; k++) f = put_stub(f, k, 3, int'($urandom));
         run_frame(f, 0);
      end
      check("wrap_chip3", bus.wrap_flag, 8'h08);

      // Clear coincident with a chip-5 write at pointer 9
      pulse_clear();
      f = rand_frame(9);
      for (int k = 0; k < 9; k++) f = put_stub(f, k, 5, int'($urandom));
      run_frame(f, 0);
      f = rand_frame(3);
      for (int k = 0; k < 3; k++) f = put_stub(f, k, 5, int'($urandom));
      bus.frame_valid = 1'b1;
      bus.frame_data  = f;
      bus.clear_ptr   = 1'b1;
      @(negedge clk);
      bus.frame_valid = 1'b0;
      bus.clear_ptr   = 1'b0;
      check("clr_wr_en", bus.wr_en, 8'h20);
      check("clr_old_addr", bus.wr_addr[5*AW +: AW], 9);
      @(negedge clk);
      check("clr_new_addr0", bus.wr_addr[5*AW +: AW], 0);
      @(negedge clk);
      check("clr_new_addr1", bus.wr_addr[5*AW +: AW], 1);
      @(negedge clk);
      check("clr_done", bus.frame_done, 1);
      @(negedge clk);
      check("clr_ready", bus.frame_ready, 1);
      check("clr_wrap", bus.wrap_flag, 0);
      model_reset();
      mptr[5] = 2;

      // Reset during stub 4 of a ten-stub frame
      bus.frame_valid = 1'b1;
      bus.frame_data  = rand_frame(10);
      repeat (5) @(negedge clk) bus.frame_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_wr_en", bus.wr_en, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_ready", bus.frame_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      mdrop = 0;
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_done", bus.frame_done, 0);
      end
      check("midrst_drop", bus.drop_cnt, 0);
      f = rand_frame(10);
      for (int k = 0; k < 10; k++) f = put_stub(f, k, int'($urandom_range(0, 7)), int'($urandom));
      run_frame(f, 0);

      // Random frames
      for (int i = 0; i < 20; i++) begin
         run_frame(rand_frame(int'($urandom_range(0, 15))), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
